// File: rtl/ds3231_pkg.sv
// Shared types and constants for the DS3231 initialisation sequencer.
package ds3231_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_e;

    // One write frame: device addr, register addr, up to four data bytes.
    localparam int DS3231_FRAME_W = 48;

    // 8-bit write address of the DS3231 (7-bit 0x68 shifted, R/W=0).
    localparam logic [7:0] DS3231_DEV_ADDR = 8'hD0;

    localparam logic [7:0] DS3231_REG_CONTROL = 8'h0E;
    localparam logic [7:0] DS3231_REG_STATUS  = 8'h0F;

    // Control: INTCN=1, RS2:RS1=11, oscillator enabled.
    localparam logic [DS3231_FRAME_W-1:0] DS3231_FRAME_CONTROL =
        {DS3231_DEV_ADDR, DS3231_REG_CONTROL, 8'h1C, 24'h000000};

    // Status: clear OSF and alarm flags, 32 kHz output off.
    localparam logic [DS3231_FRAME_W-1:0] DS3231_FRAME_STATUS =
        {DS3231_DEV_ADDR, DS3231_REG_STATUS, 8'h00, 24'h000000};

    // Counter width helper: ceil(log2(v)), never below one bit.
    function automatic int clog2_min1(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/ds3231_edge_sync.sv
// Two-flop synchroniser plus history flop; emits a one-cycle pulse on a
// rising edge of an asynchronous level input.
module ds3231_edge_sync (
    input  logic clk_250k,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;

    // Shift the input through the synchroniser and history stages.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    // Synchroniser and history registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values; the reset is asynchronous so the chain clears without a clock.
    always_ff @(posedge clk_250k or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign rise_pulse = sync2_q & ~hist_q;

endmodule

// File: rtl/ds3231_init_seq.sv
// DS3231 initialisation sequencer: on a start edge, writes NUM_FRAMES
// frames in order through the I2C write engine's write_start/write_over
// level handshake, with per-attempt timeout, bounded retry and an idle gap
// between attempts.
module ds3231_init_seq
    import ds3231_pkg::*;
#(
    parameter int FRAME_W     = DS3231_FRAME_W,
    parameter int NUM_FRAMES  = 4,
    parameter int TIMEOUT_CYC = 25000,
    parameter int MAX_RETRY   = 2,
    parameter int GAP_CYC     = 250
) (
    input  logic                                clk_250k,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [NUM_FRAMES*FRAME_W-1:0]       init_table,
    output logic                                write_start,
    output logic [FRAME_W-1:0]                  write_dat,
    input  logic                                write_over,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic [clog2_min1(NUM_FRAMES)-1:0]   frame_idx
);

    localparam int FIDX_W = clog2_min1(NUM_FRAMES);
    localparam int TMO_W  = clog2_min1(TIMEOUT_CYC);
    localparam int GAP_W  = clog2_min1(GAP_CYC + 1);
    localparam int RTY_W  = clog2_min1(MAX_RETRY + 1);

    localparam logic [FIDX_W-1:0] LAST_IDX = FIDX_W'(NUM_FRAMES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    // A zero gap still spends one cycle in GAP so write_start drops cleanly.
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [RTY_W-1:0]  RTY_MAX  = RTY_W'(MAX_RETRY);

    logic start_pe;
    logic over_pe;

    state_e             state_q,       state_d;
    logic [FIDX_W-1:0]  frame_idx_q,   frame_idx_d;
    logic [RTY_W-1:0]   retry_q,       retry_d;
    logic [TMO_W-1:0]   tmo_q,         tmo_d;
    logic [GAP_W-1:0]   gap_q,         gap_d;
    logic               write_start_q, write_start_d;
    logic [FRAME_W-1:0] write_dat_q,   write_dat_d;
    logic               busy_q,        busy_d;
    logic               done_q,        done_d;
    logic               error_q,       error_d;

    logic [FRAME_W-1:0] cur_frame;

    ds3231_edge_sync u_start_sync (
        .clk_250k   (clk_250k),
        .rst_n      (rst_n),
        .async_in   (start),
        .rise_pulse (start_pe)
    );

    ds3231_edge_sync u_over_sync (
        .clk_250k   (clk_250k),
        .rst_n      (rst_n),
        .async_in   (write_over),
        .rise_pulse (over_pe)
    );

    // Frame k lives at bits [k*FRAME_W +: FRAME_W]; the table is static while busy.
    assign cur_frame = init_table[int'(frame_idx_q)*FRAME_W +: FRAME_W];

    // Next-state and output logic for the sequencer.
    // NOTE: every signal gets a default before the case so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        frame_idx_d   = frame_idx_q;
        retry_d       = retry_q;
        tmo_d         = tmo_q;
        gap_d         = gap_q;
        write_start_d = write_start_q;
        write_dat_d   = write_dat_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        error_d       = error_q;

        unique case (state_q)
            ST_IDLE: begin
                write_start_d = 1'b0;
                write_dat_d   = '0;
                if (start_pe) begin
                    frame_idx_d = '0;
                    retry_d     = '0;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_REQ;
                end
            end

            ST_REQ: begin
                write_start_d = 1'b1;
                write_dat_d   = cur_frame;
                busy_d        = 1'b1;
                tmo_d         = '0;
                state_d       = ST_WAIT;
            end

            ST_WAIT: begin
                // Completion is checked first so it wins over a same-cycle timeout.
                if (over_pe) begin
                    write_start_d = 1'b0;
                    write_dat_d   = '0;
                    if (frame_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        frame_idx_d = frame_idx_q + 1'b1;
                        retry_d     = '0;
                        gap_d       = '0;
                        state_d     = ST_GAP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    write_start_d = 1'b0;
                    if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_GAP: begin
                write_start_d = 1'b0;
                if (gap_q == GAP_LAST) begin
                    state_d = ST_REQ;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            ST_ERR: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered-output flops; reset aborts any sequence at once.
    always_ff @(posedge clk_250k or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            frame_idx_q   <= '0;
            retry_q       <= '0;
            tmo_q         <= '0;
            gap_q         <= '0;
            write_start_q <= 1'b0;
            write_dat_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_idx_q   <= frame_idx_d;
            retry_q       <= retry_d;
            tmo_q         <= tmo_d;
            gap_q         <= gap_d;
            write_start_q <= write_start_d;
            write_dat_q   <= write_dat_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign write_start = write_start_q;
    assign write_dat   = write_dat_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign frame_idx   = frame_idx_q;

endmodule

// File: tb/tb_ds3231_init_seq.sv
// Directed bench for ds3231_init_seq: normal run, timeout + retry, retry
// exhaustion, ignored inputs, asynchronous reset and the over/timeout
// collision, against a cycle-by-cycle engine model.
module tb_ds3231_init_seq;

    localparam int FW  = 48;
    localparam int NF  = 3;
    localparam int TMO = 60;
    localparam int MR  = 2;
    localparam int GAP = 8;

    localparam logic [FW-1:0] F0 = 48'hD00E1C000000;
    localparam logic [FW-1:0] F1 = 48'hD00F00000000;
    localparam logic [FW-1:0] F2 = 48'hD01000000000;

    logic             clk_250k = 1'b0;
    logic             rst_n    = 1'b0;
    logic             start    = 1'b0;
    logic             write_over = 1'b0;
    logic [NF*FW-1:0] init_table;
    logic             write_start;
    logic [FW-1:0]    write_dat;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       frame_idx;

    always #5 clk_250k = ~clk_250k;

    ds3231_init_seq #(
        .FRAME_W     (FW),
        .NUM_FRAMES  (NF),
        .TIMEOUT_CYC (TMO),
        .MAX_RETRY   (MR),
        .GAP_CYC     (GAP)
    ) dut (
        .clk_250k    (clk_250k),
        .rst_n       (rst_n),
        .start       (start),
        .init_table  (init_table),
        .write_start (write_start),
        .write_dat   (write_dat),
        .write_over  (write_over),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .frame_idx   (frame_idx)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Engine response per attempt: cycles after write_start rise, -1 = never.
    int            resp   [8];
    int            rise_c [8];
    int            fall_c [8];
    logic [FW-1:0] dat_a  [8];
    logic [1:0]    idx_a  [8];
    int            n_att;
    int            n_done;
    int            done_c;
    logic          done_busy;
    bit            timed_out;
    int            spur_at;
    int            toggle_at;
    int            rst_at;

    // Hand-computed timeline of a clean 3-frame run (engine answers at +40).
    int exp_rise [3] = '{4, 56, 108};
    int exp_fall [3] = '{47, 99, 151};
    logic [FW-1:0] exp_dat [3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_resp(input int r0, input int r1, input int r2, input int r3, input int r4);
        resp = '{r0, r1, r2, r3, r4, -1, -1, -1};
    endtask

    // Raise start, then act as the I2C engine cycle by cycle until busy falls.
    task automatic run_seq(input int budget);
        bit ws_prev;
        bit seen_busy;
        int raise_at;
        ws_prev   = 1'b0;
        seen_busy = 1'b0;
        raise_at  = -1;
        n_att     = 0;
        n_done    = 0;
        done_c    = -1;
        done_busy = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rise_c[i] = -1;
            fall_c[i] = -1;
            dat_a[i]  = '0;
            idx_a[i]  = '0;
        end
        @(negedge clk_250k);
        start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk_250k);
            if (write_start && !ws_prev) begin
                if (n_att < 8) begin
                    rise_c[n_att] = c;
                    dat_a[n_att]  = write_dat;
                    idx_a[n_att]  = frame_idx;
                    raise_at      = (resp[n_att] >= 0) ? c + resp[n_att] : -1;
                end
                n_att++;
            end
            if (!write_start && ws_prev) begin
                if (n_att >= 1 && n_att <= 8) fall_c[n_att-1] = c;
                write_over = 1'b0;
                raise_at   = -1;
            end
            if (c == raise_at) write_over = 1'b1;
            if (spur_at >= 0 && c == spur_at) write_over = 1'b1;
            if (spur_at >= 0 && c == spur_at + 1) write_over = 1'b0;
            if (c == 10) start = 1'b0;
            if (toggle_at >= 0 && c == toggle_at) start = 1'b1;
            if (toggle_at >= 0 && c == toggle_at + 10) start = 1'b0;
            if (done) begin
                n_done++;
                done_c    = c;
                done_busy = busy;
            end
            if (busy) seen_busy = 1'b1;
            ws_prev = write_start;
            if (c == rst_at) begin
                check("pre_rst_ws",   64'(write_start), 64'd1);
                check("pre_rst_idx",  64'(frame_idx),   64'd1);
                check("pre_rst_busy", 64'(busy),        64'd1);
                #2 rst_n = 1'b0;
                #1;
                check("rst_ws",   64'(write_start), 64'd0);
                check("rst_busy", 64'(busy),        64'd0);
                check("rst_idx",  64'(frame_idx),   64'd0);
                timed_out = 1'b0;
                break;
            end
            if (seen_busy && !busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        start      = 1'b0;
        write_over = 1'b0;
        repeat (5) @(negedge clk_250k);
    endtask

    // Everything a clean 3-frame run must show.
    task automatic check_normal(input string p);
        check({p, "_budget"}, 64'(timed_out), 64'd0);
        check({p, "_n_att"},  64'(n_att),     64'd3);
        for (int a = 0; a < 3; a++) begin
            check($sformatf("%s_rise%0d", p, a), 64'(rise_c[a]), 64'(exp_rise[a]));
            check($sformatf("%s_fall%0d", p, a), 64'(fall_c[a]), 64'(exp_fall[a]));
            check($sformatf("%s_dat%0d",  p, a), 64'(dat_a[a]),  64'(exp_dat[a]));
            check($sformatf("%s_idx%0d",  p, a), 64'(idx_a[a]),  64'(a));
        end
        check({p, "_n_done"},    64'(n_done),    64'd1);
        check({p, "_done_c"},    64'(done_c),    64'd152);
        check({p, "_done_busy"}, 64'(done_busy), 64'd0);
        check({p, "_error"},     64'(error),     64'd0);
        check({p, "_dat_idle"},  64'(write_dat), 64'd0);
    endtask

    initial begin
        init_table = {F2, F1, F0};
        exp_dat    = '{F0, F1, F2};
        spur_at    = -1;
        toggle_at  = -1;
        rst_at     = -1;

        // Reset state.
        repeat (3) @(negedge clk_250k);
        check("reset_ws",    64'(write_start), 64'd0);
        check("reset_dat",   64'(write_dat),   64'd0);
        check("reset_busy",  64'(busy),        64'd0);
        check("reset_done",  64'(done),        64'd0);
        check("reset_error", 64'(error),       64'd0);
        check("reset_idx",   64'(frame_idx),   64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_250k);

        // Normal run.
        set_resp(40, 40, 40, -1, -1);
        run_seq(2000);
        check_normal("normal");

        // Frame 1 first attempt ignored: timeout, gap, retry, then success.
        set_resp(40, -1, 40, 40, -1);
        run_seq(2000);
        check("tmo_budget", 64'(timed_out), 64'd0);
        check("tmo_n_att",  64'(n_att),     64'd4);
        check("tmo_fall1",  64'(fall_c[1]), 64'd116);
        check("tmo_rise2",  64'(rise_c[2]), 64'd125);
        check("tmo_dat2",   64'(dat_a[2]),  64'(F1));
        check("tmo_idx2",   64'(idx_a[2]),  64'd1);
        check("tmo_dat3",   64'(dat_a[3]),  64'(F2));
        check("tmo_n_done", 64'(n_done),    64'd1);
        check("tmo_done_c", 64'(done_c),    64'd221);
        check("tmo_error",  64'(error),     64'd0);

        // Frame 2 never answered: three attempts, then error.
        set_resp(40, 40, -1, -1, -1);
        run_seq(2000);
        check("exh_budget", 64'(timed_out), 64'd0);
        check("exh_n_att",  64'(n_att),     64'd5);
        check("exh_rise4",  64'(rise_c[4]), 64'd246);
        check("exh_fall4",  64'(fall_c[4]), 64'd306);
        check("exh_dat4",   64'(dat_a[4]),  64'(F2));
        check("exh_idx4",   64'(idx_a[4]),  64'd2);
        check("exh_error",  64'(error),     64'd1);
        check("exh_idx",    64'(frame_idx), 64'd2);
        check("exh_busy",   64'(busy),      64'd0);
        check("exh_n_done", 64'(n_done),    64'd0);

        // Start re-toggled during WAIT and spurious write_over during GAP.
        set_resp(40, 40, 40, -1, -1);
        spur_at   = 50;
        toggle_at = 60;
        run_seq(2000);
        check_normal("ignored");
        spur_at   = -1;
        toggle_at = -1;

        // Asynchronous reset during WAIT of frame 1, then a fresh run.
        rst_at = 70;
        run_seq(2000);
        check("rst_budget", 64'(timed_out), 64'd0);
        rst_at = -1;
        rst_n  = 1'b1;
        repeat (3) @(negedge clk_250k);
        run_seq(2000);
        check_normal("rerun");

        // over_pe lands on the timeout cycle of every frame: success wins.
        set_resp(57, 57, 57, -1, -1);
        run_seq(2000);
        check("col_budget", 64'(timed_out), 64'd0);
        check("col_n_att",  64'(n_att),     64'd3);
        check("col_fall0",  64'(fall_c[0]), 64'd64);
        check("col_rise1",  64'(rise_c[1]), 64'd73);
        check("col_dat1",   64'(dat_a[1]),  64'(F1));
        check("col_idx1",   64'(idx_a[1]),  64'd1);
        check("col_dat2",   64'(dat_a[2]),  64'(F2));
        check("col_fall2",  64'(fall_c[2]), 64'd202);
        check("col_n_done", 64'(n_done),    64'd1);
        check("col_error",  64'(error),     64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ds3231_init_seq.md
Name: ds3231_init_seq

Overview:
- Parametrised DS3231 initialisation sequencer.
- One trigger writes a table of NUM_FRAMES configuration frames, in order, to the existing I2C write engine. It uses that engine's write_start/write_over level handshake.
- Adds synchronised inputs, per-frame timeout, bounded retry, inter-frame gap and busy/done/error status.
- Sits between the board control logic and the I2C write engine in the clk_250k domain.

Parameters:
- FRAME_W, 48, width of one write frame (device addr, reg addr, data bytes).
- NUM_FRAMES, 4, number of frames per sequence (1..16).
- TIMEOUT_CYC, 25000, clk_250k cycles allowed per write attempt (100 ms).
- MAX_RETRY, 2, extra attempts per frame after a timeout.
- GAP_CYC, 250, idle cycles between frames (1 ms).

Ports:
- clk_250k  in  1  system clock, 250 kHz.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  sequence trigger, asynchronous level; rising edge acts.
- init_table  in  NUM_FRAMES*FRAME_W  frame k at bits [k*FRAME_W +: FRAME_W]; must be static while busy.
- write_start  out  1  request to the I2C engine, held high until the write completes.
- write_dat  out  FRAME_W  frame being written.
- write_over  in  1  completion from the I2C engine, asynchronous; rising edge acts.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when all frames are written.
- error  out  1  sticky; set when retries are exhausted.
- frame_idx  out  clog2(NUM_FRAMES) (min 1)  current or failed frame index.

Behaviour:
- Reset is asynchronous and active-low. On reset, all outputs are 0, state is IDLE, and the synchroniser flops are 0.
- start and write_over each pass through 2 sync flops plus 1 history flop. Rising edges start_pe and over_pe are valid 3 clocks after the input rises.
- IDLE:
  - On start_pe: frame_idx=0, retry=0, error cleared, goes to REQ.
  - Otherwise write_start=0 and write_dat=0.
- REQ:
  - Drives write_dat=frame[frame_idx] and write_start=1, busy=1.
  - Loads the timeout counter with 0.
  - Goes to WAIT on the next cycle.
  - write_start rises 1 clock after start_pe.
- WAIT (write_start stays 1; timeout counter increments each cycle):
  - over_pe: write_start←0, write_dat←0. If frame_idx==NUM_FRAMES-1, go to DONE. Otherwise frame_idx+1, retry←0, go to GAP.
  - Counter reaches TIMEOUT_CYC-1 without over_pe: write_start←0. If retry<MAX_RETRY, retry+1 and go to GAP (same frame). Otherwise go to ERR.
  - over_pe and timeout in the same cycle: over_pe wins.
- GAP:
  - write_start=0; counts GAP_CYC cycles, then goes to REQ.
  - write_start is therefore low for at least GAP_CYC+1 cycles between attempts, so the engine sees a clean edge.
- DONE: done=1 for one cycle, busy←0, go to IDLE.
- ERR: error←1, busy←0, frame_idx holds the failing index, go to IDLE. error stays set until the next start_pe or reset.
- start_pe while busy is ignored; it is neither queued nor a restart.
- over_pe outside WAIT is ignored.
- Reset mid-sequence aborts immediately: write_start drops asynchronously and there is no resume.
- Counter widths:
  - timeout: clog2(TIMEOUT_CYC).
  - gap: clog2(GAP_CYC+1).
  - retry: clog2(MAX_RETRY+1), min 1.
- Counters never wrap: each is cleared on entry to its state.
- NUM_FRAMES=1 degenerates to a single write followed by DONE.

Decomposition:
- Package ds3231_pkg:
  - state enum (IDLE, REQ, WAIT, GAP, DONE, ERR).
  - FRAME_W default.
  - DS3231 device address constant 8'hD0.
  - Named default frame constants (control reg 0x0E, status reg 0x0F).
- Sub-module ds3231_edge_sync:
  - 2-flop synchroniser, history flop, rising-edge pulse out.
  - Instantiated twice (start, write_over).

Test Plan:
- Normal run: NUM_FRAMES=3, frames 48'hD00E1C000000 / 48'hD00F00000000 / 48'hD0100000_0000, engine model raises write_over 40 cycles after write_start. Required: three write_start pulses with write_dat matching each frame in order, GAP_CYC low between them, done pulses once, busy falls the same cycle, error=0.
- Single timeout then success: engine model ignores the first attempt on frame 1. Required: write_start drops at TIMEOUT_CYC; frame 1 is retried after the gap; the sequence completes with done=1 and error=0.
- Retry exhaustion: engine model never answers on frame 2 with MAX_RETRY=2. Required: exactly 3 attempts, then error=1, frame_idx=2, busy=0, and done never pulses.
- Ignored inputs: start toggled mid-sequence and a spurious write_over pulse during GAP. Required: no restart, no frame skip, same write sequence as the normal run.
- Asynchronous reset: rst_n low during WAIT of frame 1. Required: write_start, busy and frame_idx go to 0 without a clock edge. A new start then begins again from frame 0.
- Collision: write_over rises so that over_pe lands on the timeout cycle. Required: the frame counts as a success, the sequence advances and retry stays 0.
